// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 raster constants and the coordinate type
// shared by the raster generator and its consumers.
package vga_pkg;

    localparam int CLK_DIV   = 2;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div: divides the system clock down to a one-cycle pixel
// strobe, high on the last count of every CLK_DIV-cycle window.
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic pix_ce_o
);

    localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    always_comb begin
        div_d = div_q + 1'b1;
        if (div_q == LAST) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_ce_o = (div_q == LAST);

endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster generator (DrawX/DrawY, syncs, display enable, frame
// count). Define VGA_SYNC_DELAY_EN to delay syncs/display_en by one pixel.
module vga_timing #(
    parameter int CLK_DIV   = vga_pkg::CLK_DIV,
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pix_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       frame_clk,
    output logic       display_en,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    import vga_pkg::*;

    localparam int HT  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int VT  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HSS = H_VISIBLE + H_FP;
    localparam int HSE = HSS + H_SYNC;
    localparam int VSS = V_VISIBLE + V_FP;
    localparam int VSE = VSS + V_SYNC;

    coord_t     x_q, x_d;
    coord_t     y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       den_q, den_d;
    logic       fs_q, fs_d;
    logic [7:0] fcnt_q, fcnt_d;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .pix_ce_o (pix_ce)
    );

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        fs_d   = 1'b0;
        fcnt_d = fcnt_q;
        if (pix_ce) begin
            if (x_q == coord_t'(HT - 1)) begin
                x_d = '0;
                if (y_q == coord_t'(VT - 1)) begin
                    y_d    = '0;
                    fs_d   = 1'b1;
                    fcnt_d = fcnt_q + 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        // decode the current counters; lands one Clk later, same pixel
        hs_d  = !((x_q >= coord_t'(HSS)) && (x_q < coord_t'(HSE)));
        vs_d  = !((y_q >= coord_t'(VSS)) && (y_q < coord_t'(VSE)));
        den_d = (x_q < coord_t'(H_VISIBLE)) && (y_q < coord_t'(V_VISIBLE));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_q    <= '0;
            y_q    <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            den_q  <= 1'b0;
            fs_q   <= 1'b0;
            fcnt_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            den_q  <= den_d;
            fs_q   <= fs_d;
            fcnt_q <= fcnt_d;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hs_dl_q;
    logic vs_dl_q;
    logic den_dl_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hs_dl_q  <= 1'b1;
            vs_dl_q  <= 1'b1;
            den_dl_q <= 1'b0;
        end else if (pix_ce) begin
            hs_dl_q  <= hs_q;
            vs_dl_q  <= vs_q;
            den_dl_q <= den_q;
        end
    end

    assign hs         = hs_dl_q;
    assign vs         = vs_dl_q;
    assign display_en = den_dl_q;
`else
    assign hs         = hs_q;
    assign vs         = vs_q;
    assign display_en = den_q;
`endif

    assign frame_clk   = vs;
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: raster generator bench; a tiny-timing and a full 640x480
// instance are compared every Clk against an arithmetic raster model.
module tb_vga_timing;

    typedef struct packed {
        int d;
        int hv; int hfp; int hsw; int hbp;
        int vv; int vfp; int vsw; int vbp;
    } tim_t;

    localparam tim_t TS = '{d:3, hv:5, hfp:1, hsw:2, hbp:1,
                            vv:3, vfp:1, vsw:1, vbp:1};
    localparam tim_t TD = '{d:2, hv:640, hfp:16, hsw:96, hbp:48,
                            vv:480, vfp:10, vsw:2, vbp:33};
    localparam int FRAME_S = 9 * 6 * 3;

    logic Clk;
    logic Reset;

    logic       pce_s, hs_s, vs_s, fclk_s, den_s, fs_s;
    logic [9:0] dx_s, dy_s;
    logic [7:0] fcnt_s;
    logic       pce_d, hs_d, vs_d, fclk_d, den_d, fs_d;
    logic [9:0] dx_d, dy_d;
    logic [7:0] fcnt_d;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc;
    bit chk_en  = 0;
    bit long_ph = 0;
    int nfs     = 0;
    int hs_cnt  = 0;
    int hs_min  = 1023;
    int hs_max  = 0;

    vga_timing #(
        .CLK_DIV(3), .H_VISIBLE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_s (
        .Clk(Clk), .Reset(Reset), .pix_ce(pce_s),
        .DrawX(dx_s), .DrawY(dy_s), .hs(hs_s), .vs(vs_s),
        .frame_clk(fclk_s), .display_en(den_s),
        .frame_start(fs_s), .frame_cnt(fcnt_s)
    );

    vga_timing dut_d (
        .Clk(Clk), .Reset(Reset), .pix_ce(pce_d),
        .DrawX(dx_d), .DrawY(dy_d), .hs(hs_d), .vs(vs_d),
        .frame_clk(fclk_d), .display_en(den_d),
        .frame_start(fs_d), .frame_cnt(fcnt_d)
    );

    wire [33:0] pk_s = {pce_s, dx_s, dy_s, hs_s, vs_s, fclk_s,
                        den_s, fs_s, fcnt_s};
    wire [33:0] pk_d = {pce_d, dx_d, dy_d, hs_d, vs_d, fclk_d,
                        den_d, fs_d, fcnt_d};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Clk edges since the last reset release
    always @(posedge Clk or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // expected outputs after c Clk edges, from whole-pixel arithmetic
    function automatic logic [33:0] exp_out(int c, tim_t t);
        int ht, vt, ft, n, p, q, qx, qy;
        bit ce, hs, vs, den, fs, have_q;
        ht = t.hv + t.hfp + t.hsw + t.hbp;
        vt = t.vv + t.vfp + t.vsw + t.vbp;
        ft = ht * vt;
        ce = (c % t.d) == t.d - 1;
        n  = c / t.d;
        p  = n % ft;
`ifdef VGA_SYNC_DELAY_EN
        have_q = n >= 1;
        q      = (n - 1) % ft;
`else
        have_q = c >= 1;
        q      = ((c - 1) / t.d) % ft;
`endif
        hs = 1'b1; vs = 1'b1; den = 1'b0;
        if (have_q) begin
            qx  = q % ht;
            qy  = q / ht;
            hs  = !(qx >= t.hv + t.hfp && qx < t.hv + t.hfp + t.hsw);
            vs  = !(qy >= t.vv + t.vfp && qy < t.vv + t.vfp + t.vsw);
            den = (qx < t.hv) && (qy < t.vv);
        end
        fs = (c > 0) && (c % t.d == 0) && (p == 0);
        return {ce, 10'(p % ht), 10'(p / ht), hs, vs, vs, den, fs,
                8'((n / ft) % 256)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("small", 64'(pk_s), 64'(exp_out(cyc, TS)));
            chk("full", 64'(pk_d), 64'(exp_out(cyc, TD)));
            if (long_ph) begin
                if (fs_s) nfs++;
                if (pce_d && !hs_d && dy_d == 10'd0) begin
                    hs_cnt++;
                    if (int'(dx_d) < hs_min) hs_min = int'(dx_d);
                    if (int'(dx_d) > hs_max) hs_max = int'(dx_d);
                end
            end
        end
    end

    initial begin
        int exp_min;
`ifdef VGA_SYNC_DELAY_EN
        exp_min = 657;
`else
        exp_min = 656;
`endif
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk_en = 1;
        @(negedge Clk);
        #1 Reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(400, 1)) @(negedge Clk);
            @(posedge Clk);
            #2 Reset = 1'b1;
            #1;
            chk("rst_async_s", 64'(pk_s), 64'(exp_out(0, TS)));
            chk("rst_async_d", 64'(pk_d), 64'(exp_out(0, TD)));
            repeat ($urandom_range(3, 1)) @(negedge Clk);
            #1 Reset = 1'b0;
        end

        @(posedge Clk);
        #2 Reset = 1'b1;
        @(negedge Clk);
        #1 Reset = 1'b0;
        long_ph = 1;
        repeat (256 * FRAME_S + 4) @(negedge Clk);
        #1 long_ph = 0;

        chk("frame_pulses", 64'(nfs), 64'(256));
        chk("frame_cnt_wrap", 64'(fcnt_s), 64'(0));
        chk("hs_low_pix", 64'(hs_cnt), 64'(96));
        chk("hs_first_x", 64'(hs_min), 64'(exp_min));
        chk("hs_last_x", 64'(hs_max), 64'(exp_min + 95));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
